// File: rtl/fifo_uart_drain_if.sv
// Purpose: read-port bundle between a standard-mode byte FIFO and its drain.
// Latency: fifo_data is valid one clk after fifo_rd_en is sampled high.
// Backpressure: the drain pops only when fifo_empty is low; the FIFO never stalls the drain.
interface fifo_uart_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;

  // drain side: issues pops, consumes flag and data
  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data
  );

  // FIFO side: honours pops, presents flag and data
  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_uart_drain.sv
// Purpose: pops bytes from the FIFO read port and sends each as an 8N1 UART frame, LSB first.
// Latency: first START clk is 3 clks after the pop decision; a frame lasts 10*CLKS_PER_BIT clks.
// Backpressure: one pop per frame; no new pop while enable is low or the FIFO is empty.
module fifo_uart_drain #(
  parameter int CLK_FREQ_HZ = 16_000_000,
  parameter int BAUD        = 115_200,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  fifo_uart_drain_if.master  fifo,
  output logic               tx,
  output logic               busy,
  output logic [CNT_W-1:0]   bytes_sent
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_nxt;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_nxt;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_nxt;
  logic              tx_nxt;
  logic              frame_done;
  logic              baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE);

  // Next state, datapath and the line level for the coming clk; tx is registered from tx_nxt
  // so the line changes on the same edge the FSM enters a new bit period.
  always_comb begin
    state_nxt       = state;
    baud_nxt        = baud_cnt;
    bit_nxt         = bit_cnt;
    shift_nxt       = shift_reg;
    tx_nxt          = 1'b1;
    frame_done      = 1'b0;
    fifo.fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo.fifo_empty) begin
          state_nxt = POP;
        end
      end
      POP: begin
        // Gated by the flag so a pop can never reach an empty FIFO.
        fifo.fifo_rd_en = !fifo.fifo_empty;
        state_nxt       = LATCH;
      end
      LATCH: begin
        shift_nxt = fifo.fifo_data;
        baud_nxt  = '0;
        bit_nxt   = '0;
        tx_nxt    = 1'b0;
        state_nxt = START;
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          tx_nxt    = shift_reg[0];
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
          tx_nxt   = 1'b0;
        end
      end
      DATA: begin
        tx_nxt = shift_reg[0];
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            shift_nxt = {1'b0, shift_reg[7:1]};
            bit_nxt   = bit_cnt + 3'd1;
            tx_nxt    = shift_reg[1];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt   = '0;
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, counters, shift register and the registered line; reset drops any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      tx        <= tx_nxt;
    end
  end

  // Completed-frame counter, bumped on the last STOP clk; wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bytes_sent <= '0;
    end else if (frame_done) begin
      bytes_sent <= bytes_sent + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: a queue-backed FIFO model feeds one of two instances, a UART
// decoder on the selected line checks each frame against the expected-byte scoreboard.
// u_main runs at the default 138 clks/bit; u_fast (8 clks/bit, 9-bit counter) drains 512 bytes.
module tb_fifo_uart_drain;

  localparam int CPB_M = 138;
  localparam int CPB_F = 8;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        en_m     = 1'b0;
  logic        en_f     = 1'b0;
  logic        sel_fast = 1'b0;
  logic        tx_m;
  logic        busy_m;
  logic [15:0] bytes_m;
  logic        tx_f;
  logic        busy_f;
  logic [8:0]  bytes_f;

  fifo_uart_drain_if m_if();
  fifo_uart_drain_if f_if();

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       fq_empty = 1'b1;
  logic [7:0] fq_data  = 8'h00;
  int         pop_cnt  = 0;
  int         viol     = 0;
  int         cyc      = 0;
  int         vecs     = 0;
  int         errs     = 0;
  logic       rd_sel;
  logic       tx_mon;
  int         mon_cpb;

  fifo_uart_drain u_main (
    .clk        (clk),
    .rst        (rst),
    .enable     (en_m),
    .fifo       (m_if),
    .tx         (tx_m),
    .busy       (busy_m),
    .bytes_sent (bytes_m)
  );

  fifo_uart_drain #(
    .CLK_FREQ_HZ (16_000_000),
    .BAUD        (2_000_000),
    .CNT_W       (9)
  ) u_fast (
    .clk        (clk),
    .rst        (rst),
    .enable     (en_f),
    .fifo       (f_if),
    .tx         (tx_f),
    .busy       (busy_f),
    .bytes_sent (bytes_f)
  );

  always #5 clk = ~clk;

  // The unselected instance always sees an empty FIFO.
  assign m_if.fifo_empty = sel_fast | fq_empty;
  assign f_if.fifo_empty = ~sel_fast | fq_empty;
  assign m_if.fifo_data  = fq_data;
  assign f_if.fifo_data  = fq_data;
  assign rd_sel  = sel_fast ? f_if.fifo_rd_en : m_if.fifo_rd_en;
  assign tx_mon  = sel_fast ? tx_f : tx_m;
  assign mon_cpb = sel_fast ? CPB_F : CPB_M;

  // Standard-mode FIFO model: data one clk after the pop, flag reflects the queue after the edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((m_if.fifo_rd_en && m_if.fifo_empty) || (f_if.fifo_rd_en && f_if.fifo_empty))
      viol <= viol + 1;
    if (rd_sel) begin
      pop_cnt <= pop_cnt + 1;
      if (fq.size() != 0) fq_data <= fq.pop_front();
    end
    fq_empty <= (fq.size() == 0);
  end

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic push_fifo_only(input logic [7:0] b);
    fq.push_back(b);
  endtask

  // Decodes frames on the selected line (mid-bit samples) and scores them against exp_q.
  task automatic uart_monitor();
    logic       prev;
    logic       ab;
    logic [9:0] fr;
    logic [9:0] exp_fr;
    int         cpb;
    int         half;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev === 1'b1 && tx_mon === 1'b0) begin
        start_q.push_back(cyc);
        cpb  = mon_cpb;
        half = cpb / 2;
        ab   = 1'b0;
        fr   = '0;
        for (int j = 1; j <= half + 9 * cpb; j++) begin
          @(negedge clk);
          if (rst) begin
            ab = 1'b1;
            break;
          end
          if (j >= half && ((j - half) % cpb) == 0) fr[(j - half) / cpb] = tx_mon;
        end
        if (!ab) begin
          vecs++;
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL frame_unexpected got %b want none", fr);
          end else begin
            exp_fr = {1'b1, exp_q.pop_front(), 1'b0};
            if (fr !== exp_fr) begin
              errs++;
              $display("FAIL frame_data got %b want %b", fr, exp_fr);
            end
          end
        end
      end
      prev = tx_mon;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vecs++; if (tx_m !== 1'b1) begin errs++; $display("FAIL reset_tx got %b want 1", tx_m); end
    vecs++; if (busy_m !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy_m); end
    vecs++; if (m_if.fifo_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en got %b want 0", m_if.fifo_rd_en); end
    vecs++; if (bytes_m !== 16'd0) begin errs++; $display("FAIL reset_bytes got %0d want 0", bytes_m); end
    vecs++; if (tx_f !== 1'b1 || bytes_f !== 9'd0) begin errs++; $display("FAIL reset_fast got tx=%b bytes=%0d want 1/0", tx_f, bytes_f); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (tx_m !== 1'b1 || busy_m !== 1'b0) begin errs++; $display("FAIL post_reset_idle got tx=%b busy=%b want 1/0", tx_m, busy_m); end
  endtask

  task automatic test_single_55();
    logic [9:0] frame;
    int p0;
    int k;
    int bad;
    logic early;
    frame = {1'b1, 8'h55, 1'b0};
    p0 = pop_cnt;
    push_byte(8'h55);
    repeat (2) @(negedge clk);
    en_m = 1'b1;
    k = 0;
    while (tx_m !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    vecs++; if (tx_m !== 1'b0) begin errs++; $display("FAIL s55_start_timeout got tx=%b want 0", tx_m); end
    bad = 0;
    early = 1'b0;
    for (int c = 0; c < 10 * CPB_M; c++) begin
      if (tx_m !== frame[c / CPB_M]) bad++;
      if (c == 10 * CPB_M - 1 && bytes_m !== 16'd0) early = 1'b1;
      @(negedge clk);
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL s55_waveform got %0d wrong clks want 0", bad); end
    vecs++; if (early) begin errs++; $display("FAIL s55_count_early got bytes=%0d on last stop clk want 0", bytes_m); end
    vecs++; if (bytes_m !== 16'd1) begin errs++; $display("FAIL s55_bytes got %0d want 1", bytes_m); end
    vecs++; if (busy_m !== 1'b0 || tx_m !== 1'b1) begin errs++; $display("FAIL s55_idle got busy=%b tx=%b want 0/1", busy_m, tx_m); end
    repeat (50) @(negedge clk);
    vecs++; if (pop_cnt - p0 != 1) begin errs++; $display("FAIL s55_pops got %0d want 1", pop_cnt - p0); end
    vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL s55_pending got %0d want 0", exp_q.size()); end
    en_m = 1'b0;
  endtask

  task automatic test_enable_drop();
    int p0;
    int b0;
    int k;
    p0 = pop_cnt;
    b0 = int'(bytes_m);
    push_byte(8'hA3);
    push_byte(8'h3C);
    repeat (2) @(negedge clk);
    en_m = 1'b1;
    k = 0;
    while (tx_m !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    repeat (3 * CPB_M) @(negedge clk);
    en_m = 1'b0;
    k = 0;
    while (bytes_m !== 16'(b0 + 1) && k < 3000) begin @(negedge clk); k++; end
    repeat (500) @(negedge clk);
    vecs++; if (bytes_m !== 16'(b0 + 1)) begin errs++; $display("FAIL endrop_bytes got %0d want %0d", bytes_m, b0 + 1); end
    vecs++; if (pop_cnt - p0 != 1) begin errs++; $display("FAIL endrop_pops got %0d want 1", pop_cnt - p0); end
    vecs++; if (busy_m !== 1'b0 || tx_m !== 1'b1) begin errs++; $display("FAIL endrop_idle got busy=%b tx=%b want 0/1", busy_m, tx_m); end
    vecs++; if (exp_q.size() != 1) begin errs++; $display("FAIL endrop_pending got %0d want 1", exp_q.size()); end
    en_m = 1'b1;
    k = 0;
    while (bytes_m !== 16'(b0 + 2) && k < 3000) begin @(negedge clk); k++; end
    vecs++; if (bytes_m !== 16'(b0 + 2)) begin errs++; $display("FAIL resume_bytes got %0d want %0d", bytes_m, b0 + 2); end
    vecs++; if (pop_cnt - p0 != 2) begin errs++; $display("FAIL resume_pops got %0d want 2", pop_cnt - p0); end
    en_m = 1'b0;
  endtask

  task automatic test_reset_mid();
    int p0;
    int k;
    p0 = pop_cnt;
    push_fifo_only(8'h0F);
    push_byte(8'h96);
    repeat (2) @(negedge clk);
    en_m = 1'b1;
    k = 0;
    while (tx_m !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    repeat (6 * CPB_M + 20) @(negedge clk);
    vecs++; if (tx_m !== 1'b0) begin errs++; $display("FAIL rmid_pre_tx got %b want 0", tx_m); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (tx_m !== 1'b1) begin errs++; $display("FAIL rmid_tx got %b want 1", tx_m); end
    vecs++; if (busy_m !== 1'b0 || bytes_m !== 16'd0) begin errs++; $display("FAIL rmid_state got busy=%b bytes=%0d want 0/0", busy_m, bytes_m); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (bytes_m !== 16'd1 && k < 3000) begin @(negedge clk); k++; end
    vecs++; if (bytes_m !== 16'd1) begin errs++; $display("FAIL rmid_after_bytes got %0d want 1", bytes_m); end
    vecs++; if (pop_cnt - p0 != 2) begin errs++; $display("FAIL rmid_pops got %0d want 2", pop_cnt - p0); end
    vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL rmid_pending got %0d want 0", exp_q.size()); end
    en_m = 1'b0;
  endtask

  task automatic test_idle_empty();
    int p0;
    int bad_rd;
    int bad_tx;
    int bad_busy;
    p0 = pop_cnt;
    bad_rd = 0;
    bad_tx = 0;
    bad_busy = 0;
    en_m = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (m_if.fifo_rd_en !== 1'b0) bad_rd++;
      if (tx_m !== 1'b1) bad_tx++;
      if (busy_m !== 1'b0) bad_busy++;
    end
    vecs++; if (bad_rd != 0) begin errs++; $display("FAIL empty_rd_en got %0d strobes want 0", bad_rd); end
    vecs++; if (bad_tx != 0) begin errs++; $display("FAIL empty_tx got %0d low clks want 0", bad_tx); end
    vecs++; if (bad_busy != 0) begin errs++; $display("FAIL empty_busy got %0d busy clks want 0", bad_busy); end
    vecs++; if (pop_cnt != p0) begin errs++; $display("FAIL empty_pops got %0d want 0", pop_cnt - p0); end
    en_m = 1'b0;
  endtask

  task automatic test_drain_512();
    int p0;
    int k;
    sel_fast = 1'b1;
    repeat (2) @(negedge clk);
    start_q.delete();
    p0 = pop_cnt;
    for (int i = 1; i <= 512; i++) push_byte(8'(i));
    repeat (2) @(negedge clk);
    en_f = 1'b1;
    k = 0;
    while (bytes_f !== 9'd511 && k < 512 * 83 + 500) begin @(negedge clk); k++; end
    vecs++; if (bytes_f !== 9'd511) begin errs++; $display("FAIL drain_max got %0d want 511", bytes_f); end
    k = 0;
    while (bytes_f !== 9'd0 && k < 300) begin @(negedge clk); k++; end
    vecs++; if (bytes_f !== 9'd0) begin errs++; $display("FAIL drain_wrap got %0d want 0", bytes_f); end
    repeat (300) @(negedge clk);
    vecs++; if (pop_cnt - p0 != 512) begin errs++; $display("FAIL drain_pops got %0d want 512", pop_cnt - p0); end
    vecs++; if (viol != 0) begin errs++; $display("FAIL drain_pop_on_empty got %0d want 0", viol); end
    vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL drain_pending got %0d want 0", exp_q.size()); end
    vecs++; if (busy_f !== 1'b0 || tx_f !== 1'b1) begin errs++; $display("FAIL drain_idle got busy=%b tx=%b want 0/1", busy_f, tx_f); end
    vecs++; if (start_q.size() != 512) begin errs++; $display("FAIL drain_frames got %0d want 512", start_q.size()); end
    for (int i = 1; i < start_q.size(); i++) begin
      vecs++;
      if (start_q[i] - start_q[i-1] != 10 * CPB_F + 3) begin
        errs++;
        $display("FAIL drain_gap frame %0d got %0d clks want %0d", i, start_q[i] - start_q[i-1], 10 * CPB_F + 3);
      end
    end
    en_f = 1'b0;
    sel_fast = 1'b0;
  endtask

  initial begin
    test_reset();
    fork
      uart_monitor();
    join_none
    test_single_55();
    test_enable_drop();
    test_reset_mid();
    test_idle_empty();
    test_drain_512();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
